// File: rtl/dr_mem_bank.sv
// dr_mem_bank: DEPTH-entry FIFO of WIDTH-bit dual-rail words.
// Both sides use a four-phase return-to-zero handshake. Storage is
// single-rail; words are decoded on capture and re-encoded on presentation.
// The block can reset holding one INIT token so ring pipelines start live.
module dr_mem_bank #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [WIDTH-1:0] INIT       = {WIDTH{1'b0}},
    parameter bit               INIT_VALID = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*WIDTH-1:0]         in_data,
    output logic                       in_ack,
    output logic [2*WIDTH-1:0]         out_data,
    input  logic                       out_ack_i,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

    typedef enum logic [0:0] {
        I_DATA   = 1'b0,
        I_SPACER = 1'b1
    } in_state_t;

    typedef enum logic [0:0] {
        O_IDLE  = 1'b0,
        O_VALID = 1'b1
    } out_state_t;

    // Any pair carrying the illegal 11 code.
    function automatic logic word_illegal(input logic [2*WIDTH-1:0] w);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r = r | (w[2*i+1] & w[2*i]);
        end
        return r;
    endfunction

    // Every pair holds exactly one rail high (01 or 10).
    function automatic logic word_complete(input logic [2*WIDTH-1:0] w);
        logic r;
        r = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r = r & (w[2*i+1] ^ w[2*i]);
        end
        return r;
    endfunction

    // Dual-rail to single-rail: the true rail is the upper bit of each pair.
    function automatic logic [WIDTH-1:0] dr_decode(input logic [2*WIDTH-1:0] w);
        logic [WIDTH-1:0] d;
        d = {WIDTH{1'b0}};
        for (int i = 0; i < int'(WIDTH); i++) begin
            d[i] = w[2*i+1];
        end
        return d;
    endfunction

    // Single-rail to dual-rail: 1 -> 10, 0 -> 01.
    function automatic logic [2*WIDTH-1:0] dr_encode(input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] e;
        e = {(2*WIDTH){1'b0}};
        for (int i = 0; i < int'(WIDTH); i++) begin
            e[2*i+1] = d[i];
            e[2*i]   = ~d[i];
        end
        return e;
    endfunction

    // Binary pointer increment wrapping at DEPTH-1 (DEPTH need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? {PW{1'b0}} : (p + PW'(1'b1));
    endfunction

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_nx_s;
    in_state_t          in_state_r;
    in_state_t          in_state_nx_s;
    out_state_t         out_state_r;
    out_state_t         out_state_nx_s;
    logic               in_ack_r;
    logic               in_ack_nx_s;
    logic [2*WIDTH-1:0] out_data_r;
    logic [2*WIDTH-1:0] out_data_nx_s;
    logic               err_r;
    logic               illegal_s;
    logic               complete_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               load_s;

    assign illegal_s  = word_illegal(in_data);
    assign complete_s = word_complete(in_data);
    assign empty_s    = (in_data == {(2*WIDTH){1'b0}});

    // Producer-side handshake: capture complete words, release on spacer.
    always_comb begin
        in_state_nx_s = in_state_r;
        in_ack_nx_s   = in_ack_r;
        push_s        = 1'b0;
        case (in_state_r)
            I_DATA: begin
                if (illegal_s) begin
                    in_state_nx_s = I_DATA;
                end else if (complete_s && (count_r < DEPTH_C)) begin
                    push_s        = 1'b1;
                    in_ack_nx_s   = 1'b1;
                    in_state_nx_s = I_SPACER;
                end else begin
                    in_state_nx_s = I_DATA;
                end
            end
            I_SPACER: begin
                if (!illegal_s && empty_s) begin
                    in_ack_nx_s   = 1'b0;
                    in_state_nx_s = I_DATA;
                end else begin
                    in_state_nx_s = I_SPACER;
                end
            end
            default: begin
                in_ack_nx_s   = 1'b0;
                in_state_nx_s = I_DATA;
            end
        endcase
    end

    // Consumer-side handshake: present head word, pop on acknowledge.
    always_comb begin
        out_state_nx_s = out_state_r;
        load_s         = 1'b0;
        pop_s          = 1'b0;
        case (out_state_r)
            O_IDLE: begin
                if ((count_r != {CW{1'b0}}) && !out_ack_i) begin
                    load_s         = 1'b1;
                    out_state_nx_s = O_VALID;
                end else begin
                    out_state_nx_s = O_IDLE;
                end
            end
            O_VALID: begin
                if (out_ack_i) begin
                    pop_s          = 1'b1;
                    out_state_nx_s = O_IDLE;
                end else begin
                    out_state_nx_s = O_VALID;
                end
            end
            default: begin
                out_state_nx_s = O_IDLE;
            end
        endcase
    end

    // Output word only ever moves between spacer and a whole valid word.
    always_comb begin
        out_data_nx_s = out_data_r;
        if (load_s) begin
            out_data_nx_s = dr_encode(mem_r[rd_ptr_r]);
        end else if (pop_s) begin
            out_data_nx_s = {(2*WIDTH){1'b0}};
        end else begin
            out_data_nx_s = out_data_r;
        end
    end

    // Occupancy: a same-cycle push and pop cancel out.
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1'b1);
            2'b01:   count_nx_s = count_r - CW'(1'b1);
            default: count_nx_s = count_r;
        endcase
    end

    // State, pointers and registered outputs. With an initial token the write
    // pointer starts past entry 0 so the token is not overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_r  <= I_DATA;
            out_state_r <= O_IDLE;
            in_ack_r    <= 1'b0;
            out_data_r  <= {(2*WIDTH){1'b0}};
            err_r       <= 1'b0;
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= INIT_VALID ? PW'(1'b1) : {PW{1'b0}};
            count_r     <= INIT_VALID ? CW'(1'b1) : {CW{1'b0}};
        end else begin
            in_state_r  <= in_state_nx_s;
            out_state_r <= out_state_nx_s;
            in_ack_r    <= in_ack_nx_s;
            out_data_r  <= out_data_nx_s;
            err_r       <= illegal_s;
            count_r     <= count_nx_s;
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array; entry 0 preloaded with the initial token when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= ((i == 0) && INIT_VALID) ? INIT : {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= dr_decode(in_data);
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
        end
    end

    assign in_ack   = in_ack_r;
    assign out_data = out_data_r;
    assign count    = count_r;
    assign err      = err_r;

endmodule

// File: tb/tb_dr_mem_bank.sv
// Scoreboard bench for dr_mem_bank (WIDTH=8, DEPTH=4, INIT=8'hA5, INIT_VALID=1).
// Stimulus pushes expected dual-rail words into exp_q; a monitor pops and
// compares each time out_data rises from spacer to a word. A consumer process
// acknowledges words only as far as the stimulus has granted.
module tb_dr_mem_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_ack;
    logic [15:0] out_data;
    logic        out_ack_i;
    logic [2:0]  count;
    logic        err;

    int          checks;
    int          errors;
    int          cons_allow;
    logic [15:0] exp_q [$];

    dr_mem_bank #(
        .WIDTH      (8),
        .DEPTH      (4),
        .INIT       (8'hA5),
        .INIT_VALID (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_data  (out_data),
        .out_ack_i (out_ack_i),
        .count     (count),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] enc(input logic [7:0] b);
        logic [15:0] e;
        e = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            e[2*i+1] = b[i];
            e[2*i]   = ~b[i];
        end
        return e;
    endfunction

    function automatic logic is_complete(input logic [15:0] w);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = r & (w[2*i+1] ^ w[2*i]);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int n);
        cons_allow = cons_allow + n;
    endtask

    task automatic wait_ack(input logic v, input string nm);
        int n;
        n = 0;
        while (in_ack !== v && n < 30) begin
            tick();
            n++;
        end
        check(nm, 32'(in_ack), 32'(v));
    endtask

    task automatic push_word(input logic [15:0] w);
        in_data = w;
        exp_q.push_back(w);
        wait_ack(1'b1, "push_ack");
        in_data = 16'h0000;
        wait_ack(1'b0, "push_release");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((count != 3'd0 || out_data != 16'h0000) && n < 80) begin
            tick();
            n++;
        end
        check("drain_count", 32'(count), 32'd0);
    endtask

    // Consumer: four-phase acknowledge, limited by the granted word budget.
    initial begin
        int done;
        done      = 0;
        out_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!out_ack_i) begin
                if (rst_n && out_data != 16'h0000 && done < cons_allow) begin
                    out_ack_i = 1'b1;
                    done++;
                end
            end else if (out_data == 16'h0000) begin
                out_ack_i = 1'b0;
            end
        end
    end

    // Monitor: every new word on out_data is legal and matches the scoreboard.
    initial begin
        logic [15:0] prev;
        logic [15:0] want;
        prev = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 16'h0000;
            end else begin
                if (prev == 16'h0000 && out_data != 16'h0000) begin
                    check("out_word_complete", 32'(is_complete(out_data)), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected actual=%0h required=none", out_data);
                    end else begin
                        want = exp_q.pop_front();
                        check("out_word", 32'(out_data), 32'(want));
                    end
                end
                prev = out_data;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ack;
        checks     = 0;
        errors     = 0;
        cons_allow = 0;
        rst_n      = 1'b0;
        in_data    = 16'h0000;

        // 1: reset state with initial token A5 -> 9966
        #12;
        check("rst_in_ack", 32'(in_ack), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(count), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        exp_q.push_back(16'h9966);
        rst_n = 1'b1;
        tick();
        check("init_token_out", 32'(out_data), 32'h9966);
        check("init_token_count", 32'(count), 32'd1);
        grant(1);
        tick();
        check("init_pop_out", 32'(out_data), 32'd0);
        check("init_pop_count", 32'(count), 32'd0);
        tick();

        // 2: single word latency on an empty FIFO
        in_data = 16'h5555;
        exp_q.push_back(16'h5555);
        tick();
        check("t2_in_ack", 32'(in_ack), 32'd1);
        check("t2_count", 32'(count), 32'd1);
        check("t2_out_not_yet", 32'(out_data), 32'd0);
        tick();
        check("t2_out_valid", 32'(out_data), 32'h5555);
        in_data = 16'h0000;
        tick();
        check("t2_ack_release", 32'(in_ack), 32'd0);
        grant(1);
        tick();
        check("t2_pop_out", 32'(out_data), 32'd0);
        check("t2_pop_count", 32'(count), 32'd0);

        // 3: fill, stall on full, one pop admits the fifth word
        for (int i = 1; i <= 4; i++) begin
            push_word(enc(8'(i)));
        end
        check("t3_full_count", 32'(count), 32'd4);
        in_data = enc(8'h05);
        exp_q.push_back(enc(8'h05));
        tick();
        tick();
        tick();
        check("t3_stall_ack", 32'(in_ack), 32'd0);
        check("t3_stall_count", 32'(count), 32'd4);
        grant(1);
        wait_ack(1'b1, "t3_fifth_ack");
        check("t3_after_pop_count", 32'(count), 32'd4);
        in_data = 16'h0000;
        wait_ack(1'b0, "t3_fifth_release");
        grant(4);
        drain();

        // 4: illegal pair 3 -> one-cycle err, no capture
        check("t4_err_before", 32'(err), 32'd0);
        in_data = 16'h55D5;
        tick();
        check("t4_err_pulse", 32'(err), 32'd1);
        check("t4_no_ack", 32'(in_ack), 32'd0);
        check("t4_no_capture", 32'(count), 32'd0);
        in_data = 16'h0000;
        tick();
        check("t4_err_drop", 32'(err), 32'd0);
        check("t4_count_after", 32'(count), 32'd0);

        // 5: partial word held, then completed to 8'h3A
        saw_ack = 1'b0;
        in_data = 16'h0099;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_ack = saw_ack | in_ack;
        end
        check("t5_partial_no_ack", 32'(saw_ack), 32'd0);
        check("t5_partial_count", 32'(count), 32'd0);
        push_word(16'h5A99);
        grant(1);
        drain();

        // 6: simultaneous push and pop at count 2, then reset mid-handshake
        push_word(enc(8'h11));
        push_word(enc(8'h22));
        check("t6_count_two", 32'(count), 32'd2);
        in_data = enc(8'h33);
        exp_q.push_back(enc(8'h33));
        grant(1);
        tick();
        check("t6_simul_count", 32'(count), 32'd2);
        check("t6_simul_ack", 32'(in_ack), 32'd1);
        in_data = 16'h0000;
        wait_ack(1'b0, "t6_release");
        in_data = enc(8'h44);
        wait_ack(1'b1, "t6_mid_ack");
        rst_n = 1'b0;
        #1;
        check("t6_rst_in_ack", 32'(in_ack), 32'd0);
        check("t6_rst_out_data", 32'(out_data), 32'd0);
        check("t6_rst_count", 32'(count), 32'd1);
        check("t6_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        exp_q.push_back(16'h9966);
        in_data = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        grant(1);
        tick();
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
